// File: rtl/int_discriminant_queue.sv
// Queued signed-integer discriminant engine: b*b - 4ac (or b*b - ac in half-b mode).
// One shared multiplier is sequenced by a 4-state FSM fed from a small input FIFO.
module int_discriminant_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arg_vld,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    input  logic signed [W-1:0]   c,
    input  logic                  half_b_mode,
    output logic                  busy,
    output logic                  res_vld,
    output logic signed [W-1:0]   res,
    output logic signed [2*W+2:0] res_full,
    output logic                  res_negative,
    output logic                  err
);

    localparam int FW = 2 * W + 3;
    localparam int PW = 2 * W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * W + 1;

    localparam logic signed [W-1:0]  RES_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  RES_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [FW-1:0] FULL_MAX = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [FW-1:0] FULL_MIN = {{(FW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL_BB,
        MUL_AC,
        SUB
    } state_t;

    state_t state, next_state;

    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic signed [W-1:0]  opnd_a, opnd_b, opnd_c;
    logic                 opnd_half;
    logic signed [W-1:0]  mul_x, mul_y;
    logic signed [PW-1:0] mul_x_ext, mul_y_ext, prod;
    logic signed [PW-1:0] p_bb, p_ac;
    logic signed [FW-1:0] bb_ext, ac_ext, sub_term, diff;
    logic signed [W-1:0]  sat_val;
    logic                 over_hi, under_lo;

    assign busy = (count == CW'(DEPTH));
    assign push = arg_vld && !busy;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {a, b, c, half_b_mode};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = MUL_BB;
                end
            end
            MUL_BB:  next_state = MUL_AC;
            MUL_AC:  next_state = SUB;
            SUB:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are sign-extended to the product width; the upper half of the
    // multiplier inputs is pure sign, so it reduces to a single W x W multiply.
    assign mul_x     = (state == MUL_AC) ? opnd_a : opnd_b;
    assign mul_y     = (state == MUL_AC) ? opnd_c : opnd_b;
    assign mul_x_ext = {{W{mul_x[W-1]}}, mul_x};
    assign mul_y_ext = {{W{mul_y[W-1]}}, mul_y};
    assign prod      = mul_x_ext * mul_y_ext;

    always_comb begin
        bb_ext   = {{(FW-PW){p_bb[PW-1]}}, p_bb};
        ac_ext   = {{(FW-PW){p_ac[PW-1]}}, p_ac};
        sub_term = opnd_half ? ac_ext : (ac_ext <<< 2);
        diff     = bb_ext - sub_term;
        over_hi  = (diff > FULL_MAX);
        under_lo = (diff < FULL_MIN);
        sat_val  = diff[W-1:0];
        if (over_hi) begin
            sat_val = RES_MAX;
        end else if (under_lo) begin
            sat_val = RES_MIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_a       <= '0;
            opnd_b       <= '0;
            opnd_c       <= '0;
            opnd_half    <= 1'b0;
            p_bb         <= '0;
            p_ac         <= '0;
            res_vld      <= 1'b0;
            res          <= '0;
            res_full     <= '0;
            res_negative <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (pop) begin
                {opnd_a, opnd_b, opnd_c, opnd_half} <= fifo_mem[rd_ptr];
            end
            if (state == MUL_BB) begin
                p_bb <= prod;
            end
            if (state == MUL_AC) begin
                p_ac <= prod;
            end
            res_vld <= (state == SUB);
            if (state == SUB) begin
                res_full     <= diff;
                res_negative <= diff[FW-1];
                err          <= over_hi || under_lo;
                res          <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_int_discriminant_queue.sv
// Directed self-checking bench for int_discriminant_queue (W=8, DEPTH=4).
// Inputs change and outputs are sampled on falling clock edges.
module tb_int_discriminant_queue;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 2 * W + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 arg_vld;
    logic signed [W-1:0]  a, b, c;
    logic                 half_b_mode;
    logic                 busy;
    logic                 res_vld;
    logic signed [W-1:0]  res;
    logic signed [FW-1:0] res_full;
    logic                 res_negative;
    logic                 err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int m;
        int d;
        int r;
        int e;
    } vec_t;

    int_discriminant_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .arg_vld      (arg_vld),
        .a            (a),
        .b            (b),
        .c            (c),
        .half_b_mode  (half_b_mode),
        .busy         (busy),
        .res_vld      (res_vld),
        .res          (res),
        .res_full     (res_full),
        .res_negative (res_negative),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic drive(input int va, input int vb, input int vc, input int vm);
        a           = W'(va);
        b           = W'(vb);
        c           = W'(vc);
        half_b_mode = vm[0];
        arg_vld     = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        arg_vld     = 1'b0;
        a           = '0;
        b           = '0;
        c           = '0;
        half_b_mode = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
        end
        n_checks++;
        if (res_vld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_res_vld: got %b, expected 0", res_vld);
        end
        n_checks++;
        if (res !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_res: got %0d, expected 0", res);
        end
        n_checks++;
        if (res_full !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_res_full: got %0d, expected 0", res_full);
        end
        n_checks++;
        if (res_negative !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got neg=%b err=%b, expected 0 0", res_negative, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_vectors();
        vec_t v[10];
        logic signed [FW-1:0] ef;
        logic signed [W-1:0]  er;
        v[0] = '{2, 3, 4, 0, -23, -23, 0};
        v[1] = '{1, 2, 3, 1, 1, 1, 0};
        v[2] = '{1, 2, 3, 0, -8, -8, 0};
        v[3] = '{-100, 0, 100, 0, 40000, 127, 1};
        v[4] = '{100, 0, 100, 0, -40000, -128, 1};
        v[5] = '{1, 12, 17, 1, 127, 127, 0};
        v[6] = '{1, 12, 16, 1, 128, 127, 1};
        v[7] = '{32, 0, 1, 0, -128, -128, 0};
        v[8] = '{3, 0, 43, 1, -129, -128, 1};
        v[9] = '{-128, -128, -128, 0, -49152, -128, 1};
        for (int i = 0; i < 10; i++) begin
            ef = FW'(v[i].d);
            er = W'(v[i].r);
            @(negedge clk);
            drive(v[i].a, v[i].b, v[i].c, v[i].m);
            @(negedge clk);
            arg_vld = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (s > 0) @(negedge clk);
                n_checks++;
                if (res_vld !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL vec%0d_early_vld at k+%0d: got %b, expected 0", i, s, res_vld);
                end
            end
            @(negedge clk);
            n_checks++;
            if (res_vld !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_vld at k+4: got %b, expected 1", i, res_vld);
            end
            n_checks++;
            if (res !== er) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_res: got %0d, expected %0d", i, res, er);
            end
            n_checks++;
            if (res_full !== ef) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_res_full: got %0d, expected %0d", i, res_full, ef);
            end
            n_checks++;
            if (res_negative !== (v[i].d < 0)) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_res_negative: got %b, expected %b", i, res_negative, (v[i].d < 0));
            end
            n_checks++;
            if (err !== v[i].e[0]) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_err: got %b, expected %b", i, err, v[i].e[0]);
            end
            @(negedge clk);
            n_checks++;
            if (res_vld !== 1'b0 || res !== er) begin
                n_fail++;
                $display("[TB] FAIL vec%0d_hold: got vld=%b res=%0d, expected vld=0 res=%0d", i, res_vld, res, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t bv[6];
        logic exp_vld;
        int   idx;
        bv[0] = '{1, 1, 1, 0, -3, -3, 0};
        bv[1] = '{1, 4, 2, 0, 8, 8, 0};
        bv[2] = '{2, 5, 1, 1, 23, 23, 0};
        bv[3] = '{-1, 3, 2, 0, 17, 17, 0};
        bv[4] = '{3, -2, -1, 0, 16, 16, 0};
        bv[5] = '{1, 10, 1, 0, 96, 96, 0};
        for (int j = 0; j < 28; j++) begin
            if (j < 6) begin
                drive(bv[j].a, bv[j].b, bv[j].c, bv[j].m);
            end else begin
                arg_vld = 1'b0;
            end
            @(negedge clk);
            exp_vld = (j >= 4) && (j <= 20) && (j % 4 == 0);
            n_checks++;
            if (res_vld !== exp_vld) begin
                n_fail++;
                $display("[TB] FAIL burst_vld at k+%0d: got %b, expected %b", j, res_vld, exp_vld);
            end
            if (exp_vld) begin
                idx = j / 4 - 1;
                n_checks++;
                if (res !== W'(bv[idx].r) || res_full !== FW'(bv[idx].d)) begin
                    n_fail++;
                    $display("[TB] FAIL burst_res%0d: got res=%0d full=%0d, expected res=%0d full=%0d",
                             idx, res, res_full, bv[idx].r, bv[idx].d);
                end
            end
            if (j >= 3 && j <= 5) begin
                n_checks++;
                if (busy !== (j == 4)) begin
                    n_fail++;
                    $display("[TB] FAIL burst_busy at k+%0d: got %b, expected %b", j, busy, (j == 4));
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        drive(2, 3, 4, 0);
        @(negedge clk);
        arg_vld = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (res_vld !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || res_negative !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_flags: got vld=%b busy=%b err=%b neg=%b, expected all 0",
                     res_vld, busy, err, res_negative);
        end
        n_checks++;
        if (res !== '0 || res_full !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_res: got res=%0d full=%0d, expected 0 0", res, res_full);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2, 3, 4, 0);
        @(negedge clk);
        arg_vld = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge clk);
            n_checks++;
            if (res_vld !== 1'b0 || res !== '0) begin
                n_fail++;
                $display("[TB] FAIL midrst_stale at k+%0d: got vld=%b res=%0d, expected vld=0 res=0", s, res_vld, res);
            end
        end
        @(negedge clk);
        n_checks++;
        if (res_vld !== 1'b1 || res !== -8'sd23 || res_full !== -19'sd23) begin
            n_fail++;
            $display("[TB] FAIL midrst_result: got vld=%b res=%0d full=%0d, expected vld=1 res=-23 full=-23",
                     res_vld, res, res_full);
        end
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (res_vld !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midrst_extra_vld: got %b, expected 0", res_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_vectors();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
